// File: rtl/pim_sched_pkg.sv
// -----------------------------------------------------------------------------
// pim_sched_pkg
// Shared types and constants for the PIM vec-mat scheduler.
//   ADDR_W / RES_W : PIM address and result widths. They live here, not as
//                    module parameters, because the result-entry struct and the
//                    tag struct are shared by the top and the result FIFO.
//   NUM_ADDR       : size of the PIM address space (addresses wrap modulo this).
//   state_t        : scheduler FSM states.
//   res_entry_t    : one buffered result {data, addr, last}.
//   tag_t          : one tag-pipe stage {valid, addr, last}.
// -----------------------------------------------------------------------------
package pim_sched_pkg;

    localparam int ADDR_W   = 5;
    localparam int RES_W    = 18;
    localparam int NUM_ADDR = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic [RES_W-1:0]  data;
        logic [ADDR_W-1:0] addr;
        logic              last;
    } res_entry_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic              last;
    } tag_t;

endpackage

// File: rtl/pim_res_fifo.sv
// -----------------------------------------------------------------------------
// pim_res_fifo
// Synchronous FIFO holding array results until the consumer takes them.
// A push and a pop in the same cycle are both honoured, also when full.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   push, wr_data  write request and data
//   pop            read request (ignored when empty)
//   rd_data        head entry (only meaningful when !empty)
//   full, empty    occupancy flags
//   count          number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module pim_res_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only ever read
    // after it was written, and the top masks the head while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/pim_vecmat_sched.sv
// -----------------------------------------------------------------------------
// pim_vecmat_sched
// Sequencer for a 32-lane bit-sliced PIM vec-mat array. Accepts a job
// (vector + address range), holds the vector stable, sweeps the array address
// one per cycle while buffer credit allows, tags each issue, captures the
// array result PIM_LAT cycles later and streams results out with valid/ready.
// Optional feature macro: PIM_SCHED_PERF_EN adds perf_busy_cyc/perf_stall_cyc.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   req_valid/req_ready         job handshake (ready only in IDLE)
//   req_vector/base/count       job vector, first address, address count
//   pim_vector/addr/compute     array drive (registered)
//   pim_data                    array result, valid PIM_LAT cycles after issue
//   res_valid/ready/data/addr/last  result stream
//   busy                        job in progress
//   perf_busy_cyc/perf_stall_cyc   saturating counters (PIM_SCHED_PERF_EN only)
// -----------------------------------------------------------------------------
module pim_vecmat_sched
    import pim_sched_pkg::*;
#(
    parameter int VEC_W      = 512,
    parameter int PIM_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [VEC_W-1:0]  req_vector,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [ADDR_W:0]   req_count,
    output logic [VEC_W-1:0]  pim_vector,
    output logic [ADDR_W-1:0] pim_addr,
    output logic              pim_compute,
    input  logic [RES_W-1:0]  pim_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic [ADDR_W-1:0] res_addr,
    output logic              res_last,
    output logic              busy
`ifdef PIM_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_busy_cyc,
    output logic [31:0]       perf_stall_cyc
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   issued_q;
    logic [ADDR_W:0]   issued_nxt;
    logic              issue_last;
    logic [CNT_W-1:0]  inflight;
    tag_t              tag_pipe [PIM_LAT];
    tag_t              tag_out;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [CNT_W-1:0]  fifo_count;
    res_entry_t        push_entry;
    res_entry_t        head_entry;
    res_entry_t        out_entry;

    logic              credit_ok;
    logic              do_issue;

    assign issued_nxt = issued_q + 1'b1;

    // Every issue reserves a FIFO slot until its result is pushed, so the
    // array can never deliver a result with nowhere to put it.
    assign credit_ok = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
    assign do_issue  = (state == S_ISSUE) && credit_ok && !fifo_full;

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pim_vector  <= '0;
            pim_addr    <= '0;
            pim_compute <= 1'b0;
            issue_last  <= 1'b0;
            base_q      <= '0;
            count_q     <= '0;
            issued_q    <= '0;
        end else begin
            pim_compute <= 1'b0;
            issue_last  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        pim_vector <= req_vector;
                        base_q     <= req_base;
                        count_q    <= req_count;
                        issued_q   <= '0;
                        state      <= (req_count == '0) ? S_DRAIN : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (do_issue) begin
                        pim_compute <= 1'b1;
                        pim_addr    <= ADDR_W'((int'(base_q) + int'(issued_q)) % NUM_ADDR);
                        issue_last  <= (issued_nxt == count_q);
                        issued_q    <= issued_nxt;
                        if (issued_nxt == count_q) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // inflight reaches zero only once the last result is in the FIFO.
                    if (inflight == '0) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------- tag pipe and in-flight count
    // Stage 0 captures the registered issue, so the last stage lines up with
    // pim_data exactly PIM_LAT cycles after pim_compute was high.
    assign tag_out = tag_pipe[PIM_LAT-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= '0;
            for (int i = 0; i < PIM_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            inflight    <= inflight + CNT_W'(do_issue) - CNT_W'(tag_out.valid);
            tag_pipe[0] <= '{valid: pim_compute, addr: pim_addr, last: issue_last};
            for (int i = 1; i < PIM_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // ------------------------------------------------------- result buffer
    assign fifo_push  = tag_out.valid;
    assign push_entry = '{data: pim_data, addr: tag_out.addr, last: tag_out.last};
    assign res_valid  = !fifo_empty;
    assign fifo_pop   = res_valid && res_ready;

    pim_res_fifo #(
        .WIDTH($bits(res_entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_res_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (fifo_push),
        .wr_data(push_entry),
        .pop    (fifo_pop),
        .rd_data(head_entry),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_comb begin
        // NOTE: assign a default first so no path leaves out_entry unassigned
        // (otherwise a latch is inferred).
        out_entry = '0;
        if (!fifo_empty) out_entry = head_entry;
    end

    assign res_data = out_entry.data;
    assign res_addr = out_entry.addr;
    assign res_last = out_entry.last;

`ifdef PIM_SCHED_PERF_EN
    // ------------------------------------------------ saturating perf counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (busy && (perf_busy_cyc != '1))
                perf_busy_cyc <= perf_busy_cyc + 1'b1;
            if ((state == S_ISSUE) && !credit_ok && (perf_stall_cyc != '1))
                perf_stall_cyc <= perf_stall_cyc + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pim_vecmat_sched.sv
// -----------------------------------------------------------------------------
// tb_pim_vecmat_sched
// Directed bench for pim_vecmat_sched. A small PIM array model returns
// addr*10 two cycles after issue. Expected issue addresses and results are
// queued when a job is submitted and popped by monitors on the falling edge.
// -----------------------------------------------------------------------------
module tb_pim_vecmat_sched;

    localparam int VEC_W   = 512;
    localparam int ADDR_W  = 5;
    localparam int RES_W   = 18;
    localparam int NUMA    = 1 << ADDR_W;

    typedef struct {
        int data;
        int addr;
        bit last;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [VEC_W-1:0]  req_vector = '0;
    logic [ADDR_W-1:0] req_base = '0;
    logic [ADDR_W:0]   req_count = '0;
    logic [VEC_W-1:0]  pim_vector;
    logic [ADDR_W-1:0] pim_addr;
    logic              pim_compute;
    logic [RES_W-1:0]  pim_data;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [RES_W-1:0]  res_data;
    logic [ADDR_W-1:0] res_addr;
    logic              res_last;
    logic              busy;
`ifdef PIM_SCHED_PERF_EN
    logic [31:0]       perf_busy_cyc;
    logic [31:0]       perf_stall_cyc;
`endif

    int checks = 0;
    int errors = 0;
    int pop_count = 0;

    exp_t             sb[$];
    int               exp_addr_q[$];
    logic [VEC_W-1:0] exp_vec = '0;

    always #5 clk = ~clk;

    pim_vecmat_sched dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_vector (req_vector),
        .req_base   (req_base),
        .req_count  (req_count),
        .pim_vector (pim_vector),
        .pim_addr   (pim_addr),
        .pim_compute(pim_compute),
        .pim_data   (pim_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_addr   (res_addr),
        .res_last   (res_last),
        .busy       (busy)
`ifdef PIM_SCHED_PERF_EN
        ,
        .perf_busy_cyc (perf_busy_cyc),
        .perf_stall_cyc(perf_stall_cyc)
`endif
    );

    // PIM array model: result = addr*10, valid two cycles after issue.
    logic [RES_W-1:0] pim_p1 = '0;
    logic [RES_W-1:0] pim_p2 = '0;
    always @(posedge clk) begin
        pim_p1 <= pim_compute ? RES_W'(int'(pim_addr) * 10) : '0;
        pim_p2 <= pim_p1;
    end
    assign pim_data = pim_p2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue monitor: every pim_compute must match the next expected address.
    always @(negedge clk) begin
        int a;
        if (reset && pim_compute) begin
            check("issue_expected", exp_addr_q.size() > 0, 1);
            if (exp_addr_q.size() > 0) begin
                a = exp_addr_q.pop_front();
                check("pim_addr", pim_addr, a);
            end
            check("pim_vector_held", pim_vector === exp_vec, 1);
        end
    end

    // Result monitor: every accepted result must match the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (reset && res_valid && res_ready) begin
            pop_count++;
            check("result_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("res_data", res_data, e.data);
                check("res_addr", res_addr, e.addr);
                check("res_last", res_last, e.last);
            end
        end
    end

    // Held result must stay valid and unchanged until accepted.
    logic             hold_prev = 1'b0;
    logic [RES_W-1:0] prev_data;
    logic [ADDR_W-1:0] prev_addr;
    always @(negedge clk) begin
        if (!reset) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("res_valid_held", res_valid, 1);
                check("res_data_held", res_data, prev_data);
                check("res_addr_held", res_addr, prev_addr);
            end
            hold_prev = res_valid && !res_ready;
            prev_data = res_data;
            prev_addr = res_addr;
        end
    end

    task automatic submit(input int base, input int count, input logic [VEC_W-1:0] vec);
        int n = 0;
        while (!req_ready && n < 2000) begin
            tick();
            n++;
        end
        check("req_ready_for_submit", req_ready, 1);
        req_valid  = 1'b1;
        req_base   = ADDR_W'(base);
        req_count  = (ADDR_W + 1)'(count);
        req_vector = vec;
        exp_vec    = vec;
        for (int i = 0; i < count; i++) begin
            int a = (base + i) % NUMA;
            exp_addr_q.push_back(a);
            sb.push_back('{data: a * 10, addr: a, last: (i == count - 1)});
        end
        tick();
        // Garbage on the request fields must be ignored outside IDLE.
        req_valid  = 1'b0;
        req_base   = ADDR_W'($urandom());
        req_count  = (ADDR_W + 1)'($urandom_range(1, 32));
        req_vector = ~vec;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || res_valid || sb.size() != 0) && n < 2000) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, busy || res_valid || (sb.size() != 0) || (exp_addr_q.size() != 0), 0);
    endtask

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [VEC_W-1:0] v;
        for (int i = 0; i < VEC_W / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    bit   t1_cmp [9] = '{0, 1, 1, 1, 1, 0, 0, 0, 0};
    bit   t1_val [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    bit   t1_busy[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic toggle_en = 1'b0;

    initial begin
        int n;
        int n_iss;
        int pops0;

        // ---- reset values
        tick();
        tick();
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_pim_compute", pim_compute, 0);
        check("rst_pim_addr", pim_addr, 0);
        check("rst_pim_vector_zero", pim_vector == '0, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_addr", res_addr, 0);
        check("rst_res_last", res_last, 0);
        reset = 1'b1;
        tick();

        // ---- 1: base 3, count 4, cycle-accurate issue/result timing
        res_ready = 1'b1;
        submit(3, 4, rand_vec());
        for (int c = 0; c < 9; c++) begin
            check($sformatf("t1_compute_c%0d", c), pim_compute, t1_cmp[c]);
            check($sformatf("t1_res_valid_c%0d", c), res_valid, t1_val[c]);
            check($sformatf("t1_busy_c%0d", c), busy, t1_busy[c]);
            tick();
        end
        wait_idle("t1");

        // ---- 2: address wrap
        submit(30, 4, rand_vec());
        wait_idle("t2");

        // ---- 3: back-pressure limits issues to the buffer depth
        res_ready = 1'b0;
        submit(8, 16, rand_vec());
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (pim_compute) n++;
            tick();
        end
        check("t3_issues_while_stalled", n, 4);
        check("t3_compute_stalled", pim_compute, 0);
        check("t3_res_valid", res_valid, 1);
        check("t3_head_data", res_data, 80);
        check("t3_head_addr", res_addr, 8);
        pops0 = pop_count;
        res_ready = 1'b1;
        wait_idle("t3");
        check("t3_result_count", pop_count - pops0, 16);

        // ---- 4: zero-length job
        submit(5, 0, rand_vec());
        check("t4_req_ready_c0", req_ready, 0);
        check("t4_busy_c0", busy, 1);
        tick();
        check("t4_req_ready_c1", req_ready, 1);
        check("t4_busy_c1", busy, 0);
        for (int c = 0; c < 4; c++) begin
            check("t4_no_compute", pim_compute, 0);
            check("t4_no_result", res_valid, 0);
            tick();
        end

        // ---- 5: reset in the middle of ISSUE
        submit(10, 8, rand_vec());
        n_iss = 0;
        n = 0;
        while (n_iss < 2 && n < 50) begin
            tick();
            n++;
            if (pim_compute) n_iss++;
        end
        check("t5_issues_before_reset", n_iss, 2);
        reset = 1'b0;
        exp_addr_q.delete();
        sb.delete();
        #1;
        check("t5_req_ready", req_ready, 1);
        check("t5_busy", busy, 0);
        check("t5_pim_compute", pim_compute, 0);
        check("t5_pim_addr", pim_addr, 0);
        check("t5_pim_vector_zero", pim_vector == '0, 1);
        check("t5_res_valid", res_valid, 0);
        check("t5_res_data", res_data, 0);
        check("t5_res_last", res_last, 0);
        tick();
        reset = 1'b1;
        tick();
        pops0 = pop_count;
        submit(20, 3, rand_vec());
        wait_idle("t5");
        check("t5_new_job_results", pop_count - pops0, 3);

        // ---- 6: back-to-back jobs with toggling res_ready
        toggle_en = 1'b1;
        fork
            begin
                while (toggle_en) begin
                    tick();
                    res_ready = ~res_ready;
                end
            end
        join_none
        pops0 = pop_count;
        submit(5, 2, rand_vec());
        submit(12, 2, rand_vec());
        wait_idle("t6");
        toggle_en = 1'b0;
        tick();
        tick();
        res_ready = 1'b1;
        check("t6_result_count", pop_count - pops0, 4);
`ifdef PIM_SCHED_PERF_EN
        check("perf_busy_nonzero", perf_busy_cyc != 0, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
